// File: rtl/cga_pkg.sv
// cga_pkg: definitions shared by the CGA video blocks.
//   arb_state_t        - VRAM arbiter FSM states
//   VRAM_AW            - VRAM address width in bits
//   SLOT_PHASE_DEFAULT - sequencer phase in which the CPU may use VRAM;
//                        cga_sequencer keeps that phase free of display fetches
package cga_pkg;

  localparam int VRAM_AW = 19;

  localparam logic [4:0] SLOT_PHASE_DEFAULT = 5'd17;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_SLOT,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// cga_vram_arbiter_if: ISA-side CPU memory bus into the VRAM arbiter.
//   mem_cs     - CPU address decoded into the VRAM window
//   bus_memr_l - memory read strobe, asynchronous, active-low
//   bus_memw_l - memory write strobe, asynchronous, active-low
//   bus_a      - CPU byte address within VRAM
//   bus_d      - CPU write data
//   bus_rdy    - ISA ready, low inserts wait states
//   cpu_rdata  - CPU read data, held until the next read
// master = ISA decode / CPU side, slave = arbiter.
interface cga_vram_arbiter_if;
  logic        mem_cs;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic [14:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_rdy;
  logic [7:0]  cpu_rdata;

  modport master (
    output mem_cs, bus_memr_l, bus_memw_l, bus_a, bus_d,
    input  bus_rdy, cpu_rdata
  );

  modport slave (
    input  mem_cs, bus_memr_l, bus_memw_l, bus_a, bus_d,
    output bus_rdy, cpu_rdata
  );
endinterface

// File: rtl/cga_strobe_sync.sv
// cga_strobe_sync: two-flop synchroniser for the asynchronous ISA memory
// strobes. Reset parks both outputs at the inactive (high) level.
//   clk, reset     - system clock, asynchronous active-high reset
//   memr_l, memw_l - raw active-low read/write strobes
//   memr_s, memw_s - synchronised strobes, still active-low
module cga_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic memr_l,
  input  logic memw_l,
  output logic memr_s,
  output logic memw_s
);

  logic memr_p0, memr_p1;
  logic memw_p0, memw_p1;

  // p0: first flop, may go metastable; p1: settled copy used by the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memr_p0 <= 1'b1;
      memr_p1 <= 1'b1;
      memw_p0 <= 1'b1;
      memw_p1 <= 1'b1;
    end else begin
      memr_p0 <= memr_l;
      memr_p1 <= memr_p0;
      memw_p0 <= memw_l;
      memw_p1 <= memw_p0;
    end
  end

  assign memr_s = memr_p1;
  assign memw_s = memw_p1;

endmodule

// File: rtl/cga_vram_arbiter.sv
// cga_vram_arbiter: shares the single VRAM port between display fetch and
// CPU accesses. The display always wins; a CPU access starts only in the
// sequencer slot SLOT_PHASE when the display is idle, holds the RAM for
// ACCESS_CYCLES clocks and is retried in a later slot if the display
// grabs the port mid-access.
//   clk, reset - system clock, asynchronous active-high reset
//   clk_seq    - sequencer phase counter (wraps freely)
//   disp_req   - display owns the RAM port this cycle
//   disp_a     - display fetch address
//   isa        - CPU bus (strobes, address, data, ready, read data)
//   ram_a      - RAM address
//   ram_we_l   - RAM write enable, active-low
//   ram_dout   - RAM write data (latched CPU data)
//   ram_d      - RAM read data
//   collision  - high for the cycle in which a CPU access is aborted
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int                 USE_BUS_WAIT  = 1,
  parameter logic [4:0]         SLOT_PHASE    = SLOT_PHASE_DEFAULT,
  parameter int                 ACCESS_CYCLES = 2,
  parameter logic [VRAM_AW-1:0] CPU_BASE      = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         clk_seq,
  input  logic               disp_req,
  input  logic [VRAM_AW-1:0] disp_a,
  cga_vram_arbiter_if.slave  isa,
  output logic [VRAM_AW-1:0] ram_a,
  output logic               ram_we_l,
  output logic [7:0]         ram_dout,
  input  logic [7:0]         ram_d,
  output logic               collision
);

  localparam logic [2:0] CNT_LOAD = 3'(ACCESS_CYCLES - 1);

  logic memr_s, memw_s;

  cga_strobe_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .memr_l (isa.bus_memr_l),
    .memw_l (isa.bus_memw_l),
    .memr_s (memr_s),
    .memw_s (memw_s)
  );

  arb_state_t         state, state_n;
  logic [2:0]         cnt, cnt_n;
  logic [VRAM_AW-1:0] lat_a, lat_a_n;
  logic [7:0]         lat_d, lat_d_n;
  logic               lat_wr, lat_wr_n;
  logic [7:0]         rdata, rdata_n;
  logic               we_reg, we_n;
  logic               rdy_reg, rdy_n;
  logic               req;

  // A write strobe wins when both are low.
  assign req = isa.mem_cs & (~memr_s | ~memw_s);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    lat_a_n  = lat_a;
    lat_d_n  = lat_d;
    lat_wr_n = lat_wr;
    rdata_n  = rdata;
    rdy_n    = rdy_reg;
    we_n     = 1'b1;
    case (state)
      ARB_IDLE: begin
        if (req) begin
          state_n  = ARB_WAIT_SLOT;
          lat_a_n  = {4'b0, isa.bus_a} + CPU_BASE;
          lat_d_n  = isa.bus_d;
          lat_wr_n = ~memw_s;
          rdy_n    = 1'b0;
        end
      end
      ARB_WAIT_SLOT: begin
        if (clk_seq == SLOT_PHASE && !disp_req) begin
          state_n = ARB_ACCESS;
          cnt_n   = CNT_LOAD;
          we_n    = ~lat_wr;
        end
      end
      ARB_ACCESS: begin
        if (disp_req) begin
          // Display took the port: drop this attempt, keep the request.
          state_n = ARB_WAIT_SLOT;
          cnt_n   = CNT_LOAD;
        end else if (cnt == 3'd0) begin
          state_n = ARB_DONE;
          if (!lat_wr) rdata_n = ram_d;
        end else begin
          cnt_n = cnt - 3'd1;
          we_n  = ~lat_wr;
        end
      end
      ARB_DONE: begin
        rdy_n = 1'b1;
        // Wait for the strobe to release so one strobe is served once.
        if (memr_s && memw_s) state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ARB_IDLE;
      cnt     <= 3'd0;
      lat_a   <= '0;
      lat_d   <= 8'h00;
      lat_wr  <= 1'b0;
      rdata   <= 8'h00;
      we_reg  <= 1'b1;
      rdy_reg <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lat_a   <= lat_a_n;
      lat_d   <= lat_d_n;
      lat_wr  <= lat_wr_n;
      rdata   <= rdata_n;
      we_reg  <= we_n;
      rdy_reg <= rdy_n;
    end
  end

  // disp_req overrides the registered enable in the same cycle.
  assign ram_we_l      = we_reg | disp_req;
  assign ram_a         = (state == ARB_ACCESS && !disp_req) ? lat_a : disp_a;
  assign ram_dout      = lat_d;
  assign collision     = (state == ARB_ACCESS) && disp_req;
  assign isa.cpu_rdata = rdata;
  assign isa.bus_rdy   = (USE_BUS_WAIT != 0) ? rdy_reg : 1'b1;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// tb_cga_vram_arbiter: randomized bench for cga_vram_arbiter. Two DUTs
// share the stimulus: dut0 with default parameters, dut1 without bus wait
// states and with a non-zero CPU_BASE. Each transaction's RAM schedule is
// computed up front from the slot/priority rules and checked cycle by cycle.
module tb_cga_vram_arbiter;
  import cga_pkg::*;

  localparam int          A     = 2;
  localparam int          NCYC  = 128;
  localparam logic [4:0]  SLOT  = 5'd17;
  localparam logic [18:0] BASE1 = 19'h40000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  clk_seq;
  logic        disp_req;
  logic [18:0] disp_a;
  logic [7:0]  ram_d;
  logic [18:0] ram_a0, ram_a1;
  logic        we0, we1, col0, col1;
  logic [7:0]  dout0, dout1;

  cga_vram_arbiter_if isa0 ();
  cga_vram_arbiter_if isa1 ();

  assign isa1.mem_cs     = isa0.mem_cs;
  assign isa1.bus_memr_l = isa0.bus_memr_l;
  assign isa1.bus_memw_l = isa0.bus_memw_l;
  assign isa1.bus_a      = isa0.bus_a;
  assign isa1.bus_d      = isa0.bus_d;

  always #5 clk = ~clk;

  cga_vram_arbiter dut0 (
    .clk(clk), .reset(reset), .clk_seq(clk_seq), .disp_req(disp_req),
    .disp_a(disp_a), .isa(isa0), .ram_a(ram_a0), .ram_we_l(we0),
    .ram_dout(dout0), .ram_d(ram_d), .collision(col0)
  );

  cga_vram_arbiter #(.USE_BUS_WAIT(0), .CPU_BASE(BASE1)) dut1 (
    .clk(clk), .reset(reset), .clk_seq(clk_seq), .disp_req(disp_req),
    .disp_a(disp_a), .isa(isa1), .ram_a(ram_a1), .ram_we_l(we1),
    .ram_dout(dout1), .ram_d(ram_d), .collision(col1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int g_seq;
  logic [7:0] prev_rdata;
  logic [7:0] prev_dout;

  logic        disp_arr [NCYC];
  logic [18:0] da_arr   [NCYC];
  logic [7:0]  rd_arr   [NCYC];
  bit          acc      [NCYC];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [4:0] seq_at(input int seq0, input int i);
    return 5'((seq0 + i) % 32);
  endfunction

  // kind: 0 read, 1 write, 2 both strobes low, 3 write strobe without mem_cs
  // dmode: 0 display idle, 1 random display traffic, 2 display hits the
  //        first access cycle. rel: cycle in which the strobe is released.
  task automatic run_txn(input int kind, input logic [14:0] addr, input logic [7:0] data,
                         input int dmode, input int rel);
    bit active, is_wr, is_rd, ok;
    int seq0, e, n, ab, we_cnt;
    logic [18:0] exp_a;
    active = (kind != 3);
    is_wr  = (kind == 1 || kind == 2);
    is_rd  = (kind == 0);
    seq0   = g_seq;
    e      = -1;
    we_cnt = 0;

    for (int i = 0; i < NCYC; i++) begin
      disp_arr[i] = (dmode == 1) ? ($urandom_range(3) == 0) : 1'b0;
      da_arr[i]   = 19'($urandom);
      rd_arr[i]   = 8'($urandom);
      acc[i]      = 1'b0;
      // late in the window the slot is kept clear so the access must finish
      if (dmode == 1 && i >= 70 && seq_at(seq0, i) >= SLOT && seq_at(seq0, i) <= SLOT + 5'(A))
        disp_arr[i] = 1'b0;
    end
    if (dmode == 2) begin
      ok = 1'b0;
      for (int i = 3; i < NCYC - 1; i++)
        if (!ok && seq_at(seq0, i) == SLOT) begin
          disp_arr[i+1] = 1'b1;
          ok = 1'b1;
        end
    end

    // Expected RAM schedule: request seen after 2 sync cycles, latched
    // into the slot wait from cycle 3; each free slot starts A access
    // cycles, display activity in any of them aborts and waits again.
    if (active) begin
      n = 3;
      while (n < NCYC - A && e < 0) begin
        if (seq_at(seq0, n) == SLOT && !disp_arr[n]) begin
          ab = -1;
          for (int j = 1; j <= A; j++) begin
            if (ab < 0) begin
              acc[n+j] = 1'b1;
              if (disp_arr[n+j]) ab = n + j;
            end
          end
          if (ab < 0) e = n + A;
          else n = ab + 1;
        end else begin
          n++;
        end
      end
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      clk_seq         = seq_at(seq0, c);
      disp_req        = disp_arr[c];
      disp_a          = da_arr[c];
      ram_d           = rd_arr[c];
      isa0.mem_cs     = (kind != 3);
      isa0.bus_memr_l = !((kind == 0 || kind == 2) && c < rel);
      isa0.bus_memw_l = !((kind != 0) && c < rel);
      isa0.bus_a      = (c < 4) ? addr : 15'($urandom);
      isa0.bus_d      = (c < 4) ? data : 8'($urandom);
      #4;
      ok = acc[c] && !disp_arr[c];
      check_val("we0", we0, !(is_wr && ok));
      check_val("we1", we1, !(is_wr && ok));
      exp_a = ok ? 19'(addr) : da_arr[c];
      check_val("ram_a0", ram_a0, exp_a);
      exp_a = ok ? 19'(addr) + BASE1 : da_arr[c];
      check_val("ram_a1", ram_a1, exp_a);
      check_val("collision0", col0, acc[c] && disp_arr[c]);
      check_val("collision1", col1, acc[c] && disp_arr[c]);
      check_val("bus_rdy0", isa0.bus_rdy, !active || c < 3 || c >= e + 2);
      check_val("bus_rdy1", isa1.bus_rdy, 1);
      check_val("rdata0", isa0.cpu_rdata, (is_rd && c >= e + 1) ? rd_arr[e] : prev_rdata);
      check_val("rdata1", isa1.cpu_rdata, (is_rd && c >= e + 1) ? rd_arr[e] : prev_rdata);
      check_val("dout0", dout0, (active && c >= 3) ? data : prev_dout);
      check_val("dout1", dout1, (active && c >= 3) ? data : prev_dout);
      if (we0 === 1'b0) we_cnt++;
    end
    check_val("write_cycles", we_cnt, is_wr ? A : 0);
    if (is_rd) prev_rdata = rd_arr[e];
    if (active) prev_dout = data;
    g_seq += NCYC;
  endtask

  task automatic run_reset_mid_access();
    bit hit;
    hit = 1'b0;
    isa0.mem_cs     = 1'b1;
    isa0.bus_memr_l = 1'b1;
    isa0.bus_memw_l = 1'b0;
    isa0.bus_a      = 15'($urandom);
    isa0.bus_d      = 8'($urandom);
    for (int c = 0; c < 80; c++) begin
      if (!hit) begin
        @(posedge clk);
        #1;
        clk_seq  = 5'(g_seq % 32);
        g_seq++;
        disp_req = 1'b0;
        disp_a   = 19'($urandom);
        ram_d    = 8'($urandom);
        #4;
        if (we0 === 1'b0) hit = 1'b1;
      end
    end
    check_val("rst_reached_access", hit, 1);
    reset = 1'b1;
    #1;
    check_val("rst_async_we0", we0, 1);
    check_val("rst_async_we1", we1, 1);
    check_val("rst_async_rdy0", isa0.bus_rdy, 1);
    check_val("rst_async_col0", col0, 0);
    isa0.bus_memw_l = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    prev_rdata = 8'h00;
    prev_dout  = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      clk_seq  = 5'(g_seq % 32);
      g_seq++;
      disp_a   = 19'($urandom);
      #4;
      check_val("post_rst_we0", we0, 1);
      check_val("post_rst_we1", we1, 1);
      check_val("post_rst_rdy0", isa0.bus_rdy, 1);
      check_val("post_rst_ram_a0", ram_a0, disp_a);
      check_val("post_rst_dout0", dout0, 8'h00);
    end
    g_seq += (32 - (g_seq % 32)) % 32;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, dm, rl;
    reset           = 1'b1;
    clk_seq         = 5'd0;
    disp_req        = 1'b0;
    disp_a          = 19'h12345;
    ram_d           = 8'h00;
    isa0.mem_cs     = 1'b0;
    isa0.bus_memr_l = 1'b1;
    isa0.bus_memw_l = 1'b1;
    isa0.bus_a      = 15'h0;
    isa0.bus_d      = 8'h0;
    g_seq           = int'($urandom_range(31));
    prev_rdata      = 8'h00;
    prev_dout       = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_rdy0", isa0.bus_rdy, 1);
    check_val("reset_rdy1", isa1.bus_rdy, 1);
    check_val("reset_we0", we0, 1);
    check_val("reset_we1", we1, 1);
    check_val("reset_rdata0", isa0.cpu_rdata, 8'h00);
    check_val("reset_col0", col0, 0);
    check_val("reset_dout0", dout0, 8'h00);
    check_val("reset_ram_a0", ram_a0, 19'h12345);
    @(posedge clk);
    #1 reset = 1'b0;

    run_txn(1, 15'h0010, 8'hA5, 0, 50);
    run_txn(0, 15'h1234, 8'h00, 0, 50);
    run_txn(1, 15'h7FFF, 8'h96, 2, 90);
    run_txn(0, 15'h0ABC, 8'h00, 2, 90);
    run_txn(2, 15'h0200, 8'h55, 0, 100);
    run_txn(3, 15'h0300, 8'h77, 1, 30);
    run_txn(1, 15'h0400, 8'h3C, 0, 1);
    run_txn(0, 15'h0500, 8'h00, 1, 3);

    run_reset_mid_access();
    run_txn(1, 15'h0600, 8'hC3, 0, 40);

    for (int t = 0; t < 20; t++) begin
      k  = int'($urandom_range(3));
      dm = int'($urandom_range(2));
      rl = ($urandom_range(1) == 1) ? int'($urandom_range(8, 1)) : int'($urandom_range(100, 40));
      run_txn(k, 15'($urandom), 8'($urandom), dm, rl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
